// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: oversamples the PS/2 lines, frames 11-bit packets,
// folds E0/F0 prefixes into flags and buffers scancodes in a show-ahead FIFO.
module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int PREFIX_DECODE  = 1
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    input  logic                              rd_en,
    output logic [7:0]                        code,
    output logic                              is_ext,
    output logic                              is_break,
    output logic                              valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              frame_err,
    output logic                              overflow
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DECODE} state_t;

    state_t                 state, stateNext;
    logic [SYNC_STAGES-1:0] clkSync, dataSync;
    logic                   clkPrev, fall, bitIn;
    logic [2:0]             bitIdx;
    logic [7:0]             shiftReg;
    logic                   parityBit, frameGood;
    logic [TW-1:0]          toCnt;
    logic                   timeoutHit, badFrame, shiftEn, parityEn;
    logic                   pushReq, setExt, setBrk;
    logic                   extPend, brkPend;

    logic [9:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]          wrPtr, rdPtr;
    logic [CW-1:0]          cnt;
    logic [9:0]             lastHead, headEntry;
    logic                   pop, full, doPush;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clkSync  <= '1;
            dataSync <= '1;
            clkPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[SYNC_STAGES-2:0], ps2_clk};
            dataSync <= {dataSync[SYNC_STAGES-2:0], ps2_data};
            clkPrev  <= clkSync[SYNC_STAGES-1];
        end
    end

    assign fall       = clkPrev & ~clkSync[SYNC_STAGES-1];
    assign bitIn      = dataSync[SYNC_STAGES-1];
    assign frameGood  = bitIn & (^{shiftReg, parityBit});
    assign timeoutHit = (state == DATA || state == PARITY || state == STOP) &&
                        !fall && (toCnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (fall && !bitIn) stateNext = DATA;
            DATA:    if (timeoutHit) stateNext = IDLE;
                     else if (fall && bitIdx == 3'd7) stateNext = PARITY;
            PARITY:  if (timeoutHit) stateNext = IDLE;
                     else if (fall) stateNext = STOP;
            STOP:    if (timeoutHit) stateNext = IDLE;
                     else if (fall) stateNext = frameGood ? DECODE : IDLE;
            DECODE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        shiftEn  = (state == DATA) && fall;
        parityEn = (state == PARITY) && fall;
        badFrame = (state == STOP) && fall && !frameGood;
        setExt   = 1'b0;
        setBrk   = 1'b0;
        pushReq  = 1'b0;
        if (state == DECODE) begin
            if (PREFIX_DECODE != 0 && shiftReg == 8'hE0)      setExt  = 1'b1;
            else if (PREFIX_DECODE != 0 && shiftReg == 8'hF0) setBrk  = 1'b1;
            else                                              pushReq = 1'b1;
        end
    end

    // Prefix flags survive aborted frames; only an actual push attempt clears them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bitIdx    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            toCnt     <= '0;
            extPend   <= 1'b0;
            brkPend   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= badFrame | timeoutHit;
            if (state == IDLE) begin
                bitIdx <= '0;
                if (fall && !bitIn) shiftReg <= '0;
            end else if (shiftEn) begin
                shiftReg[bitIdx] <= bitIn;
                bitIdx           <= bitIdx + 3'd1;
            end
            if (parityEn) parityBit <= bitIn;
            if (state == IDLE || state == DECODE || fall) toCnt <= '0;
            else                                          toCnt <= toCnt + 1'b1;
            if (pushReq) begin
                extPend <= 1'b0;
                brkPend <= 1'b0;
            end else begin
                if (setExt) extPend <= 1'b1;
                if (setBrk) brkPend <= 1'b1;
            end
        end
    end

    assign valid     = (cnt != '0);
    assign full      = (cnt == CW'(FIFO_DEPTH));
    assign pop       = rd_en & valid;
    assign doPush    = pushReq & (!full | pop);
    assign headEntry = mem[rdPtr];
    assign count     = cnt;
    assign {is_ext, is_break, code} = valid ? headEntry : lastHead;

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= {extPend, brkPend, shiftReg};
    end

    // lastHead keeps the head visible after the FIFO drains.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cnt      <= '0;
            lastHead <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= pushReq & full & !pop;
            if (valid)  lastHead <= headEntry;
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (pop)    rdPtr <= rdPtr + 1'b1;
            case ({doPush, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: drives PS/2 frames and checks FIFO heads against
// a queue of expected {is_ext, is_break, code} entries.
module tb_ps2_scancode_rx;

    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int HALF  = 10;

    logic       clock = 1'b0, resetn = 1'b0;
    logic       ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0, rawRd = 1'b0;
    logic [7:0] code, rawCode;
    logic       is_ext, is_break, valid, frame_err, overflow;
    logic       rawExt, rawBrk, rawValid, rawErr, rawOvf;
    logic [2:0] count, rawCount;

    int         compared = 0, mismatched = 0;
    int         errPulses = 0, ovfPulses = 0;
    logic [9:0] expQ[$];

    ps2_scancode_rx #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .PREFIX_DECODE(1)) dut (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .code(code), .is_ext(is_ext), .is_break(is_break), .valid(valid), .count(count),
        .frame_err(frame_err), .overflow(overflow));

    ps2_scancode_rx #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .PREFIX_DECODE(0)) dutRaw (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rawRd),
        .code(rawCode), .is_ext(rawExt), .is_break(rawBrk), .valid(rawValid), .count(rawCount),
        .frame_err(rawErr), .overflow(rawOvf));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (frame_err === 1'b1) errPulses++;
        if (overflow === 1'b1) ovfPulses++;
    end

    function automatic logic [10:0] makeFrame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Bits go out LSB first; popAtStop raises rd_en in the cycle the stop bit's push lands.
    task automatic sendBits(input logic [10:0] frame, input int nbits, input bit popAtStop);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            if (popAtStop && i == 10) begin
                repeat (SYNC + 1) @(negedge clock);
                rd_en = 1'b1;
                @(negedge clock);
                rd_en = 1'b0;
                repeat (HALF - SYNC - 2) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        sendBits(makeFrame(b), 11, 1'b0);
        repeat (HALF) @(negedge clock);
    endtask

    task automatic popHead(output logic [9:0] obs, output logic obsValid);
        obs      = {is_ext, is_break, code};
        obsValid = valid;
        rd_en    = 1'b1;
        @(negedge clock);
        rd_en    = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        compared++;
        if ({code, is_ext, is_break, valid, count, frame_err, overflow} !== 15'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got code=%h ext=%b brk=%b valid=%b count=%0d err=%b ovf=%b, want all 0",
                     code, is_ext, is_break, valid, count, frame_err, overflow);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single();
        logic [9:0] obs, exp;
        logic       ov;
        sendByte(8'h1C);
        expQ.push_back({2'b00, 8'h1C});
        compared++;
        if (count !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL single_count: got %0d, want 1", count);
        end
        popHead(obs, ov);
        exp = expQ.pop_front();
        compared++;
        if (ov !== 1'b1 || obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL single_head: got valid=%b entry=%h, want valid=1 entry=%h", ov, obs, exp);
        end
        compared++;
        if (valid !== 1'b0 || count !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL single_drained: got valid=%b count=%0d, want 0/0", valid, count);
        end
    endtask

    task automatic test_prefix();
        logic [9:0] obs, exp;
        logic       ov;
        sendByte(8'hF0);
        sendByte(8'h1C);
        expQ.push_back({2'b01, 8'h1C});
        compared++;
        if (count !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL break_count: got %0d, want 1", count);
        end
        popHead(obs, ov);
        exp = expQ.pop_front();
        compared++;
        if (ov !== 1'b1 || obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL break_head: got valid=%b entry=%h, want entry=%h", ov, obs, exp);
        end
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        expQ.push_back({2'b11, 8'h75});
        compared++;
        if (count !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL ext_break_count: got %0d, want 1", count);
        end
        popHead(obs, ov);
        exp = expQ.pop_front();
        compared++;
        if (ov !== 1'b1 || obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL ext_break_head: got valid=%b entry=%h, want entry=%h", ov, obs, exp);
        end
    endtask

    task automatic test_errors();
        logic [10:0] f;
        logic [9:0]  obs, exp;
        logic        ov;
        int          base;
        for (int k = 0; k < 2; k++) begin
            f = makeFrame(8'h1C);
            if (k == 0) f[9] = ~f[9];
            else        f[10] = 1'b0;
            base = errPulses;
            sendBits(f, 11, 1'b0);
            repeat (HALF) @(negedge clock);
            compared++;
            if (errPulses - base !== 1 || count !== 3'd0) begin
                mismatched++;
                $display("[TB] FAIL bad_frame_%0d: got err pulses=%0d count=%0d, want 1/0", k, errPulses - base, count);
            end
        end
        sendByte(8'h1C);
        expQ.push_back({2'b00, 8'h1C});
        popHead(obs, ov);
        exp = expQ.pop_front();
        compared++;
        if (ov !== 1'b1 || obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL after_error_head: got valid=%b entry=%h, want entry=%h", ov, obs, exp);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] obs, exp;
        logic       ov;
        int         base;
        base = errPulses;
        sendBits(makeFrame(8'h1C), 6, 1'b0);
        repeat (TMO + 20) @(negedge clock);
        compared++;
        if (errPulses - base !== 1 || count !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL timeout_err: got err pulses=%0d count=%0d, want 1/0", errPulses - base, count);
        end
        sendByte(8'h1C);
        expQ.push_back({2'b00, 8'h1C});
        popHead(obs, ov);
        exp = expQ.pop_front();
        compared++;
        if (ov !== 1'b1 || obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL timeout_recover: got valid=%b entry=%h, want entry=%h", ov, obs, exp);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        logic [9:0] obs, exp;
        logic       ov;
        int         base;
        base = ovfPulses;
        for (int i = 0; i < 5; i++) begin
            sendByte(codes[i]);
            if (i < DEPTH) expQ.push_back({2'b00, codes[i]});
        end
        compared++;
        if (count !== 3'd4 || ovfPulses - base !== 1) begin
            mismatched++;
            $display("[TB] FAIL overflow_full: got count=%0d ovf pulses=%0d, want 4/1", count, ovfPulses - base);
        end
        for (int i = 0; i < DEPTH; i++) begin
            popHead(obs, ov);
            exp = expQ.pop_front();
            compared++;
            if (ov !== 1'b1 || obs !== exp) begin
                mismatched++;
                $display("[TB] FAIL overflow_pop%0d: got valid=%b entry=%h, want entry=%h", i, ov, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [4] = '{8'h15, 8'h1D, 8'h24, 8'h2D};
        logic [9:0] obs, exp;
        logic       ov;
        int         base;
        for (int i = 0; i < 4; i++) begin
            sendByte(codes[i]);
            expQ.push_back({2'b00, codes[i]});
        end
        compared++;
        if ({is_ext, is_break, code} !== expQ[0]) begin
            mismatched++;
            $display("[TB] FAIL b2b_head_before: got %h, want %h", {is_ext, is_break, code}, expQ[0]);
        end
        void'(expQ.pop_front());
        base = ovfPulses;
        sendBits(makeFrame(8'h2C), 11, 1'b1);
        repeat (HALF) @(negedge clock);
        expQ.push_back({2'b00, 8'h2C});
        compared++;
        if (count !== 3'd4 || ovfPulses - base !== 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_full: got count=%0d ovf pulses=%0d, want 4/0", count, ovfPulses - base);
        end
        for (int i = 0; i < DEPTH; i++) begin
            popHead(obs, ov);
            exp = expQ.pop_front();
            compared++;
            if (ov !== 1'b1 || obs !== exp) begin
                mismatched++;
                $display("[TB] FAIL b2b_pop%0d: got valid=%b entry=%h, want entry=%h", i, ov, obs, exp);
            end
        end
    endtask

    task automatic test_reset_midframe();
        sendByte(8'h5A);
        sendBits(makeFrame(8'h33), 4, 1'b0);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        compared++;
        if ({code, is_ext, is_break, valid, count, frame_err, overflow} !== 15'd0 || rawCount !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL midframe_reset: got code=%h ext=%b brk=%b valid=%b count=%0d raw count=%0d, want all 0",
                     code, is_ext, is_break, valid, count, rawCount);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_raw();
        logic [9:0] obs, exp;
        logic       ov;
        sendByte(8'hF0);
        compared++;
        if (rawCount !== 3'd1 || rawValid !== 1'b1 || {rawExt, rawBrk, rawCode} !== {2'b00, 8'hF0}) begin
            mismatched++;
            $display("[TB] FAIL raw_f0: got count=%0d entry=%h, want 1/0f0", rawCount, {rawExt, rawBrk, rawCode});
        end
        compared++;
        if (count !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL prefix_absorbed: got count=%0d, want 0", count);
        end
        rawRd = 1'b1;
        @(negedge clock);
        rawRd = 1'b0;
        sendByte(8'h1C);
        expQ.push_back({2'b01, 8'h1C});
        popHead(obs, ov);
        exp = expQ.pop_front();
        compared++;
        if (ov !== 1'b1 || obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL post_reset_break: got valid=%b entry=%h, want entry=%h", ov, obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_errors();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_raw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
